// File: rtl/led_blink_meter.sv
// Receive-side meter for a blinking input: measures the half-period in ms,
// reports each measurement, flags lock on repeats and detects a steady input.
module led_blink_meter #(
  parameter int unsigned CLKS_PER_MS = 100000,
  parameter int unsigned TIMEOUT_MS  = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        blink_in,
  output logic [15:0] interval,
  output logic        meas_valid,
  output logic        locked,
  output logic        timeout,
  output logic        level
);

  localparam int unsigned PW          = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_MS - 1);
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_MS);

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_MEASURE = 1'b1;

  logic          s1_q, s2_q, s3_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic [0:0]    state_q, state_d;
  logic [15:0]   interval_q, interval_d;
  logic          meas_valid_q, meas_valid_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   prev_meas_q, prev_meas_d;

  logic          edge_seen;
  logic          tick;
  logic [16:0]   half_sum;
  logic [15:0]   half;

  assign edge_seen = s2_q ^ s3_q;
  assign tick      = (presc_q == PRESC_MAX);

  // A tick landing in the edge cycle still counts towards the sample.
  assign half_sum  = {1'b0, ms_cnt_q} + 17'(tick);
  assign half      = half_sum[16] ? 16'hFFFF : half_sum[15:0];

  always_comb begin
    presc_d      = (edge_seen || tick) ? '0 : presc_q + 1'b1;
    ms_cnt_d     = ms_cnt_q;
    state_d      = state_q;
    interval_d   = interval_q;
    meas_valid_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;
    prev_meas_d  = prev_meas_q;

    case (state_q)
      ST_HUNT: begin
        ms_cnt_d = '0;
        if (edge_seen) begin
          state_d = ST_MEASURE;
        end
      end
      default: begin
        ms_cnt_d = half;
        if (edge_seen) begin
          ms_cnt_d = '0;
          if (half == 16'd0) begin
            locked_d = 1'b0;
          end else begin
            interval_d   = half;
            meas_valid_d = 1'b1;
            locked_d     = (half == prev_meas_q);
            prev_meas_d  = half;
          end
        end else if (half >= TIMEOUT_LIM) begin
          ms_cnt_d    = '0;
          interval_d  = '0;
          locked_d    = 1'b0;
          prev_meas_d = '0;
          timeout_d   = 1'b1;
          state_d     = ST_HUNT;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      presc_q      <= '0;
      ms_cnt_q     <= '0;
      state_q      <= ST_HUNT;
      interval_q   <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
      prev_meas_q  <= '0;
    end else begin
      s1_q         <= blink_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      presc_q      <= presc_d;
      ms_cnt_q     <= ms_cnt_d;
      state_q      <= state_d;
      interval_q   <= interval_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      timeout_q    <= timeout_d;
      prev_meas_q  <= prev_meas_d;
    end
  end

  assign interval   = interval_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
  assign level      = s2_q;

endmodule

// File: tb/tb_led_blink_meter.sv
// Bench for led_blink_meter: scenario table, hand-written corner sequences and
// random toggling, all compared cycle by cycle against an elapsed-time model.
module tb_led_blink_meter;

  localparam int unsigned C = 10;
  localparam int unsigned T = 20;

  logic        clk;
  logic        rst_n;
  logic        blink_in;
  logic [15:0] interval;
  logic        meas_valid;
  logic        locked;
  logic        timeout;
  logic        level;

  led_blink_meter #(
    .CLKS_PER_MS(C),
    .TIMEOUT_MS (T)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blink_in  (blink_in),
    .interval  (interval),
    .meas_valid(meas_valid),
    .locked    (locked),
    .timeout   (timeout),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int valid_cnt = 0;

  // Reference model: time since last input edge, in cycles, divided into ms.
  int unsigned cyc = 0;
  int unsigned last_edge = 0;
  bit          m_hunt = 1'b1;
  logic        m_s1 = 1'b0, m_s2 = 1'b0, m_s3 = 1'b0;
  logic [15:0] m_interval = '0, m_prev = '0;
  logic        m_valid = 1'b0, m_locked = 1'b0, m_tout = 1'b0;

  task automatic model_step();
    logic        e;
    int unsigned half;
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
      m_hunt = 1'b1;
      m_interval = '0; m_prev = '0;
      m_valid = 1'b0; m_locked = 1'b0; m_tout = 1'b0;
    end else begin
      e    = m_s2 ^ m_s3;
      half = (cyc - last_edge) / C;
      if (half > 65535) half = 65535;
      m_valid = 1'b0;
      m_tout  = 1'b0;
      if (m_hunt) begin
        if (e) begin
          m_hunt    = 1'b0;
          last_edge = cyc;
        end
      end else if (e) begin
        last_edge = cyc;
        if (half == 0) begin
          m_locked = 1'b0;
        end else begin
          m_interval = 16'(half);
          m_valid    = 1'b1;
          m_locked   = (16'(half) == m_prev);
          m_prev     = 16'(half);
        end
      end else if (half >= T) begin
        m_interval = '0;
        m_locked   = 1'b0;
        m_prev     = '0;
        m_tout     = 1'b1;
        m_hunt     = 1'b1;
      end
      m_s3 = m_s2;
      m_s2 = m_s1;
      m_s1 = blink_in;
    end
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    checks++;
    if (interval !== m_interval || meas_valid !== m_valid || locked !== m_locked ||
        timeout !== m_tout || level !== m_s2) begin
      failures++;
      $display("FAIL model cyc=%0d got int=%0d v=%b lk=%b to=%b lv=%b exp int=%0d v=%b lk=%b to=%b lv=%b",
               cyc, interval, meas_valid, locked, timeout, level,
               m_interval, m_valid, m_locked, m_tout, m_s2);
    end
    if (meas_valid === 1'b1) valid_cnt++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {11'd0, interval, meas_valid, locked, timeout, level}, 32'd0);
  endtask

  typedef struct {
    int unsigned period;
    int unsigned toggles;
    int unsigned exp_valids;
    logic [15:0] exp_interval;
    logic        exp_locked;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int unsigned spent;
    int          k;
    int unsigned gap;

    tbl[0] = '{period: 50,  toggles: 4, exp_valids: 3, exp_interval: 16'd5,  exp_locked: 1'b1};
    tbl[1] = '{period: 80,  toggles: 1, exp_valids: 1, exp_interval: 16'd8,  exp_locked: 1'b0};
    tbl[2] = '{period: 80,  toggles: 1, exp_valids: 1, exp_interval: 16'd8,  exp_locked: 1'b1};
    tbl[3] = '{period: 35,  toggles: 3, exp_valids: 3, exp_interval: 16'd3,  exp_locked: 1'b1};
    tbl[4] = '{period: 9,   toggles: 1, exp_valids: 0, exp_interval: 16'd3,  exp_locked: 1'b0};
    tbl[5] = '{period: 40,  toggles: 2, exp_valids: 2, exp_interval: 16'd4,  exp_locked: 1'b1};
    tbl[6] = '{period: 199, toggles: 1, exp_valids: 1, exp_interval: 16'd19, exp_locked: 1'b0};
    tbl[7] = '{period: 45,  toggles: 2, exp_valids: 2, exp_interval: 16'd4,  exp_locked: 1'b1};

    // Reset held 3 cycles while the input toggles.
    rst_n    = 1'b0;
    blink_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blink_in = ~blink_in;
      step();
      check_all_zero("reset_hold");
    end
    blink_in = 1'b0;
    rst_n    = 1'b1;
    step();
    check_all_zero("reset_release");

    // Scenario table.
    spent = 0;
    for (int r = 0; r < 8; r++) begin
      valid_cnt = 0;
      for (int unsigned i = 0; i < tbl[r].toggles; i++) begin
        repeat (tbl[r].period - spent) step();
        spent    = 0;
        blink_in = ~blink_in;
      end
      repeat (5) step();
      spent = 5;
      check($sformatf("row%0d_valids", r), valid_cnt, tbl[r].exp_valids);
      check($sformatf("row%0d_interval", r), {16'd0, interval}, {16'd0, tbl[r].exp_interval});
      check($sformatf("row%0d_locked", r), {31'd0, locked}, {31'd0, tbl[r].exp_locked});
    end

    // Steady input: timeout strobe 200 cycles after the last detected edge.
    k = 5;
    while (timeout !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    check("timeout_latency", k, 203);
    check("timeout_interval", {16'd0, interval}, 32'd0);
    check("timeout_locked", {31'd0, locked}, 32'd0);
    valid_cnt = 0;
    blink_in  = ~blink_in;
    repeat (10) step();
    check("hunt_edge_no_meas", valid_cnt, 0);

    // Relock at 5 ms, then a 3-clk glitch shortly after an edge.
    repeat (40) step();
    blink_in = ~blink_in;
    repeat (50) step();
    blink_in = ~blink_in;
    repeat (5) step();
    check("pre_glitch_locked", {31'd0, locked}, 32'd1);
    valid_cnt = 0;
    blink_in  = ~blink_in;
    repeat (3) step();
    blink_in = ~blink_in;
    repeat (10) step();
    check("glitch_no_valid", valid_cnt, 0);
    check("glitch_unlocked", {31'd0, locked}, 32'd0);
    check("glitch_interval", {16'd0, interval}, 32'd5);
    repeat (40) step();
    blink_in = ~blink_in;
    repeat (5) step();
    check("resume_valid", valid_cnt, 1);
    check("resume_interval", {16'd0, interval}, 32'd5);

    // One-cycle reset mid-period; relock needs three fresh edges.
    repeat (15) step();
    rst_n    = 1'b0;
    blink_in = 1'b0;
    step();
    rst_n = 1'b1;
    check_all_zero("mid_reset_clear");
    repeat (50) step();
    blink_in = ~blink_in;
    repeat (50) step();
    blink_in = ~blink_in;
    repeat (5) step();
    check("relock_edge2_locked", {31'd0, locked}, 32'd0);
    check("relock_edge2_interval", {16'd0, interval}, 32'd5);
    repeat (45) step();
    blink_in = ~blink_in;
    repeat (5) step();
    check("relock_edge3_locked", {31'd0, locked}, 32'd1);

    // Random gaps, including glitches, timeouts and occasional resets.
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(1, 260);
      repeat (gap) step();
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        blink_in = ~blink_in;
      end
    end
    repeat (250) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
